// File: rtl/eb_sink_if.sv
// ============================================================================
// eb_sink_if : req/ack elastic-buffer stream bundle (t_req / t_ack / t_dat)
// Rev 1.0
// ============================================================================
`default_nettype none

interface eb_sink_if #(
    parameter int W = 32
);
    logic         t_req;
    logic         t_ack;
    logic [W-1:0] t_dat;

    modport master (output t_req, output t_dat, input t_ack);
    modport slave  (input t_req, input t_dat, output t_ack);
endinterface

`default_nettype wire

// File: rtl/eb_sink.sv
// ============================================================================
// eb_sink : stream consumer with LFSR backpressure and incrementing-sequence check
// Optional macro EB_SINK_PROTO_CHECK_EN enables the stall-protocol monitor. Rev 1.0
// ============================================================================
`default_nettype none

module eb_sink #(
    parameter int          W    = 32,
    parameter int          CW   = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          reset_n,
    eb_sink_if.slave      t,
    input  logic          enable,
    input  logic [4:0]    duty,
    output logic          locked,
    output logic          mismatch,
    output logic [CW-1:0] xfer_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          proto_err
);

    localparam logic [0:0]  S_SYNC = 1'b0;
    localparam logic [0:0]  S_RUN  = 1'b1;
    localparam logic [15:0] C_TAPS = 16'hB400;

    logic [0:0]    state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          t_ack_q, t_ack_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [W-1:0]  exp_q, exp_d;
    logic          mismatch_q, mismatch_d;
    logic          xf;
    logic          bad;

    assign xf  = t.t_req & t_ack_q;
    assign bad = (state_q == S_RUN) && xf && (t.t_dat != exp_q);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN is absorbing until reset
    always_comb begin
        state_d = state_q;
        if (state_q == S_SYNC && xf) begin
            state_d = S_RUN;
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_TAPS : 16'h0000);
        t_ack_d    = enable & (duty[4] | (lfsr_q[3:0] < duty[3:0]));
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;
        exp_d      = exp_q;
        mismatch_d = bad;
        if (xf) begin
            xfer_cnt_d = xfer_cnt_q + CW'(1);
            exp_d      = t.t_dat + W'(1);
        end
        if (bad && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_d = err_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q     <= SEED;
            t_ack_q    <= 1'b0;
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            t_ack_q    <= t_ack_d;
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
        end
    end

`ifdef EB_SINK_PROTO_CHECK_EN
    logic         pend_q;
    logic [W-1:0] shadow_q;
    logic         proto_q, proto_d;

    // A stalled request must stay asserted with stable data until accepted
    always_comb begin
        proto_d = proto_q | (pend_q & (~t.t_req | (t.t_dat != shadow_q)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= 1'b0;
            shadow_q <= '0;
            proto_q  <= 1'b0;
        end else begin
            pend_q   <= t.t_req & ~t_ack_q;
            shadow_q <= t.t_dat;
            proto_q  <= proto_d;
        end
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

    assign t.t_ack   = t_ack_q;
    assign locked    = (state_q == S_RUN);
    assign mismatch  = mismatch_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_eb_sink.sv
// ============================================================================
// tb_eb_sink : directed self-checking bench for eb_sink (CW=16 and CW=2 instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_eb_sink;

`ifdef EB_SINK_PROTO_CHECK_EN
    localparam logic c_PROTO = 1'b1;
`else
    localparam logic c_PROTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [4:0]  duty;
    logic        t_req;
    logic [31:0] t_dat;

    logic        locked, mismatch, proto_err;
    logic [15:0] xfer_cnt, err_cnt;
    logic        locked2, mismatch2, proto_err2;
    logic [1:0]  xfer_cnt2, err_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    bit          sb_q[$];
    bit          m_locked;
    logic [31:0] m_exp;

    eb_sink_if #(.W(32)) bus ();
    eb_sink_if #(.W(32)) bus2 ();

    assign bus.t_req  = t_req;
    assign bus.t_dat  = t_dat;
    assign bus2.t_req = t_req;
    assign bus2.t_dat = t_dat;

    eb_sink #(.W(32), .CW(16), .SEED(16'hACE1)) dut (
        .clk(clk), .reset_n(reset_n), .t(bus.slave), .enable(enable), .duty(duty),
        .locked(locked), .mismatch(mismatch), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt),
        .proto_err(proto_err)
    );

    eb_sink #(.W(32), .CW(2), .SEED(16'hACE1)) dut2 (
        .clk(clk), .reset_n(reset_n), .t(bus2.slave), .enable(enable), .duty(duty),
        .locked(locked2), .mismatch(mismatch2), .xfer_cnt(xfer_cnt2), .err_cnt(err_cnt2),
        .proto_err(proto_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset 5 cycles; the request is dropped before release
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (5) tick();
        t_req    = 1'b0;
        reset_n  = 1'b1;
        m_locked = 1'b0;
        m_exp    = '0;
        sb_q.delete();
    endtask

    task automatic send(input logic [31:0] v);
        bit got;
        bit a;
        got   = 1'b0;
        t_req = 1'b1;
        t_dat = v;
        sb_q.push_back(m_locked && (v != m_exp));
        m_locked = 1'b1;
        m_exp    = v + 32'd1;
        for (int i = 0; i < 64 && !got; i++) begin
            a = bus.t_ack;
            tick();
            if (a) begin
                got = 1'b1;
                check("mismatch", mismatch, sb_q.pop_front());
            end
        end
        check("xf_timeout", got, 1);
    endtask

    task automatic idle();
        t_req = 1'b0;
        tick();
    endtask

    initial begin
        int          n_ack;
        int          n_xf;
        int          m_cnt;
        logic [15:0] m_lfsr;
        bit          a;

        reset_n = 1'b0;
        enable  = 1'b1;
        duty    = 5'd16;
        t_req   = 1'b1;
        t_dat   = '0;

        // Reset with request held high
        repeat (5) tick();
        check("rst_t_ack",    bus.t_ack, 0);
        check("rst_xfer_cnt", xfer_cnt,  0);
        check("rst_err_cnt",  err_cnt,   0);
        check("rst_locked",   locked,    0);
        check("rst_mismatch", mismatch,  0);
        check("rst_proto",    proto_err, 0);
        t_req   = 1'b0;
        reset_n = 1'b1;
        m_locked = 1'b0;
        check("rel_t_ack", bus.t_ack, 0);
        tick();
        check("rel_t_ack_up", bus.t_ack, 1);

        // Full rate 0x10..0x1F
        send(32'h10);
        check("locked_first", locked, 1);
        for (int v = 'h11; v <= 'h1F; v++) send(32'(v));
        idle();
        check("full_xfer_cnt", xfer_cnt, 16);
        check("full_err_cnt",  err_cnt,  0);
        check("full_err_cnt2", err_cnt2, 0);

        // Gap: 5,6,8,9
        do_reset();
        send(32'd5); send(32'd6); send(32'd8); send(32'd9);
        idle();
        check("gap_err_cnt",  err_cnt,  1);
        check("gap_xfer_cnt", xfer_cnt, 4);
        check("gap_mismatch_clear", mismatch, 0);

        // Wrap through all-ones
        do_reset();
        send(32'hFFFF_FFFE); send(32'hFFFF_FFFF); send(32'h0000_0000);
        idle();
        check("wrap_err_cnt",  err_cnt,  0);
        check("wrap_xfer_cnt", xfer_cnt, 3);

        // Five gaps: wide counter 5, narrow counter saturates at 3
        do_reset();
        for (int v = 0; v <= 10; v += 2) send(32'(v));
        idle();
        check("sat_err_cnt",   err_cnt,   5);
        check("sat_err_cnt2",  err_cnt2,  3);
        check("sat_xfer_cnt2", xfer_cnt2, 2);

        // Enable drop coinciding with a transfer
        t_req  = 1'b1;
        t_dat  = 32'd11;
        enable = 1'b0;
        tick();
        t_req = 1'b0;
        check("en_drop_t_ack", bus.t_ack, 0);
        check("en_drop_xfer",  xfer_cnt,  7);
        check("en_drop_mism",  mismatch,  0);
        tick();
        check("en_drop_hold",  bus.t_ack, 0);
        enable = 1'b1;

        // duty=0: never ready
        duty = 5'd0;
        do_reset();
        t_req = 1'b1;
        t_dat = 32'h77;
        n_ack = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.t_ack) n_ack++;
        end
        check("duty0_acks", n_ack,    0);
        check("duty0_xfer", xfer_cnt, 0);

        // duty=8 over 4096 cycles against an LFSR model
        duty = 5'd8;
        do_reset();
        t_req  = 1'b1;
        t_dat  = '0;
        n_ack  = 0;
        n_xf   = 0;
        m_cnt  = 0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 4096; i++) begin
            a = bus.t_ack;
            if (m_lfsr[3:0] < 4'd8) m_cnt++;
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            tick();
            if (a) begin
                n_xf++;
                t_dat = t_dat + 32'd1;
            end
            if (bus.t_ack) n_ack++;
        end
        check("duty8_model", n_ack, m_cnt);
        check("duty8_range", (n_ack >= 1920 && n_ack <= 2176), 1);
        check("duty8_xfer",  xfer_cnt, 16'(n_xf));
        check("duty8_err",   err_cnt,  0);

        // Protocol: request withdrawn while stalled
        duty = 5'd0;
        do_reset();
        check("proto_rst", proto_err, 0);
        t_req = 1'b1;
        t_dat = 32'h55;
        repeat (3) tick();
        check("proto_stall_ok", proto_err, 0);
        t_req = 1'b0;
        tick();
        check("proto_withdraw", proto_err, c_PROTO);
        duty = 5'd16;
        tick();
        send(32'd0); send(32'd1); send(32'd2);
        idle();
        check("proto_sticky", proto_err, c_PROTO);

        // Protocol: data changed while stalled
        duty = 5'd0;
        do_reset();
        check("proto_rst2", proto_err, 0);
        t_req = 1'b1;
        t_dat = 32'hA;
        repeat (2) tick();
        t_dat = 32'hB;
        tick();
        check("proto_datachg", proto_err, c_PROTO);
        t_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
